pos_seq_ctrl: RTL and testbench
===============================

# pos_seq_ctrl

Sequencing controller for the k-NN position averager. Accepts the K nearest labels one at a time from the upstream sorter over a valid/ready stream and accumulates their x and y halves. It then divides both sums by K_NUM with a shared-schedule iterative divider and presents the averaged coordinates on a valid/ready output. It replaces the free-running combinational average with a framed, back-pressurable pipeline stage between the k-NN selector and the coordinate consumer.

## Interface
- LBL_LEN, 10: label width; x = label[LBL_LEN-1:LBL_LEN/2], y = label[LBL_LEN/2-1:0]
- K_NUM, 5: labels per frame (≥2)
- SUM_W, $clog2((2**(LBL_LEN/2)-1)*K_NUM): accumulator width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns to COLLECT, drops partial frame
- in_valid  in  1  label valid
- in_ready  out  1  label accepted when in_valid & in_ready
- in_lbl  in  LBL_LEN  label
- out_valid  out  1  averaged coordinates valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_x  out  LBL_LEN/2  floor(sum_x / K_NUM)
- out_y  out  LBL_LEN/2  floor(sum_y / K_NUM)
- busy  out  1  high in DIV or OUT

## Operation
- States: COLLECT, DIV, OUT. Reset state COLLECT.
- COLLECT: in_ready=1. Each accept adds the x half to sum_x and the y half to sum_y (zero-extended to SUM_W) and increments cnt. The accept with cnt==K_NUM-1 moves to DIV and clears cnt.
- DIV: in_ready=0. Restoring division of sum_x and sum_y by K_NUM in parallel, one quotient bit per cycle, MSB first, SUM_W cycles, driven by a step counter. After the last step, quotients are latched into out_x/out_y and the state moves to OUT.
- OUT: out_valid=1, out_x/out_y held stable until the handshake. On out_valid & out_ready: sums cleared, go to COLLECT.
- Arithmetic: sums never overflow (max (2^(LBL_LEN/2)-1)*K_NUM fits SUM_W). Quotient ≤ 2^(LBL_LEN/2)-1; the upper quotient bits are zero and are dropped. Truncating division, no rounding.
- clear: has priority over every transition in every state. Next cycle: COLLECT, cnt=0, sums=0, out_valid=0. out_x/out_y keep their last value.
- in_valid while in_ready=0: ignored, no accept. in_lbl is not sampled outside COLLECT.
- Reset values: state COLLECT, in_ready=1, out_valid=0, busy=0, out_x=0, out_y=0, sums=0, cnt=0.

## Timing
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid/out_ready to any output.
- Throughput: one label per cycle in COLLECT.
- Latency: out_valid rises on the SUM_W+1-th rising edge after the edge that accepts the K-th label (9 edges at defaults).
- The first label of the next frame can be accepted on the edge after the output handshake.
- Frame period at defaults with out_ready tied high: K_NUM + SUM_W + 2 = 15 cycles.
- Reset asserted mid-frame or mid-DIV: immediate return to reset values; the partial frame is lost.

## Structure
- Package knn_pkg: LBL_LEN and K_NUM defaults, the SUM_W width function, the state enum (COLLECT/DIV/OUT), and x/y field-extraction functions. Shared with the k-NN selector and pos_finder.
- One sub-module, seq_div_const: iterative restoring divider of a SUM_W-bit dividend by the constant K_NUM, with start/done and a quotient output. Instantiated twice (x and y), started in the same cycle, so both finish together.
- Top: FSM, accumulators, label counter, output registers.

## Test plan
- Labels (x,y) (1,2),(3,4),(5,6),(7,8),(9,10) back to back, out_ready=1 -> out_x=5, out_y=6; out_valid rises 9 edges after the 5th accept and stays high 1 cycle.
- All five labels = 10'h3FF -> out_x=31, out_y=31 (sum 155 without overflow).
- x = 1,1,1,1,2, y = 0,0,0,0,4 -> out_x=1, out_y=0 (truncation).
- out_ready=0 for 20 cycles after out_valid -> out_x/out_y stable, in_ready=0 throughout, no new label accepted; on release the next frame starts the following edge.
- Three labels accepted, then clear pulsed -> next five labels (2,2)x5 yield out_x=2, out_y=2 (no contamination from the partial frame).
- rst_n pulsed low during DIV -> all outputs return to reset values at once; the next full frame averages correctly.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared k-NN definitions: default sizes, FSM state type and label field helpers.
// Used by the k-NN selector, pos_finder and the position-averaging sequencer.
package knn_pkg;

    localparam int LBL_LEN_DEF = 10;
    localparam int K_NUM_DEF   = 5;

    typedef enum logic [1:0] {
        COLLECT,
        DIV,
        OUT
    } state_t;

    // Accumulator width: must hold K_NUM copies of the largest half-label.
    function automatic int sum_w(input int lbl_len, input int k_num);
        return $clog2(((2 ** (lbl_len / 2)) - 1) * k_num);
    endfunction

    function automatic logic [15:0] lbl_x(input logic [31:0] lbl, input int lbl_len);
        logic [31:0] t;
        t = lbl >> (lbl_len / 2);
        return 16'(t & ((32'd1 << (lbl_len / 2)) - 32'd1));
    endfunction

    function automatic logic [15:0] lbl_y(input logic [31:0] lbl, input int lbl_len);
        return 16'(lbl & ((32'd1 << (lbl_len / 2)) - 32'd1));
    endfunction

endpackage

// File: rtl/pos_seq_ctrl_if.sv
// Label input stream and averaged-coordinate output stream of pos_seq_ctrl.
interface pos_seq_ctrl_if #(
    parameter int LBL_LEN = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LBL_LEN-1:0]     in_lbl;
    logic                   out_valid;
    logic                   out_ready;
    logic [LBL_LEN/2-1:0]   out_x;
    logic [LBL_LEN/2-1:0]   out_y;

    modport master (
        output in_valid, in_lbl, out_ready,
        input  in_ready, out_valid, out_x, out_y
    );

    modport slave (
        input  in_valid, in_lbl, out_ready,
        output in_ready, out_valid, out_x, out_y
    );
endinterface

// File: rtl/seq_div_const.sv
// Iterative restoring divider by a constant: one quotient bit per cycle, MSB first.
// The start cycle already performs the first step, so done follows SUM_W edges later.
module seq_div_const #(
    parameter int SUM_W   = 8,
    parameter int DIVISOR = 5,
    parameter int Q_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic [SUM_W-1:0] dvd,
    output logic             done,
    output logic [Q_W-1:0]   quo
);
    localparam int DW   = $clog2(DIVISOR);
    localparam int CNTW = $clog2(SUM_W);

    logic [SUM_W-1:0] sh, src;
    logic [DW-1:0]    rem, rem_in;
    logic [DW:0]      trial;
    logic             ge, run;
    logic [CNTW-1:0]  steps, steps_nx;

    // sh shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        run      = start || (steps != '0);
        src      = start ? dvd : sh;
        rem_in   = start ? '0 : rem;
        trial    = {rem_in, src[SUM_W-1]};
        ge       = trial >= (DW+1)'(DIVISOR);
        steps_nx = start ? CNTW'(SUM_W - 1) : steps - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            rem   <= '0;
            steps <= '0;
            done  <= 1'b0;
        end else if (abort) begin
            sh    <= '0;
            rem   <= '0;
            steps <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (run) begin
                sh    <= {src[SUM_W-2:0], ge};
                rem   <= ge ? DW'(trial - (DW+1)'(DIVISOR)) : trial[DW-1:0];
                steps <= steps_nx;
                done  <= (steps_nx == '0);
            end
        end
    end

    assign quo = sh[Q_W-1:0];

endmodule

// File: rtl/pos_seq_ctrl.sv
// Framed k-NN position averager: collects K_NUM labels, divides the x/y sums by
// K_NUM with two lock-stepped iterative dividers and offers the result on a stream.
module pos_seq_ctrl
    import knn_pkg::*;
#(
    parameter int LBL_LEN = LBL_LEN_DEF,
    parameter int K_NUM   = K_NUM_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    pos_seq_ctrl_if.slave      bus,
    output logic               busy
);
    localparam int HALF  = LBL_LEN / 2;
    localparam int SUM_W = sum_w(LBL_LEN, K_NUM);
    localparam int CW    = $clog2(K_NUM);

    state_t            state;
    logic [SUM_W-1:0]  sum_x, sum_y;
    logic [CW-1:0]     cnt;
    logic              div_start;
    logic              done_x, done_y;
    logic [HALF-1:0]   quo_x, quo_y;
    logic [31:0]       lbl_w;

    assign lbl_w         = 32'(bus.in_lbl);
    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == OUT);
    assign busy          = (state != COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            sum_x     <= '0;
            sum_y     <= '0;
            cnt       <= '0;
            div_start <= 1'b0;
            bus.out_x <= '0;
            bus.out_y <= '0;
        end else if (clear) begin
            state     <= COLLECT;
            sum_x     <= '0;
            sum_y     <= '0;
            cnt       <= '0;
            div_start <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        sum_x <= sum_x + SUM_W'(lbl_x(lbl_w, LBL_LEN));
                        sum_y <= sum_y + SUM_W'(lbl_y(lbl_w, LBL_LEN));
                        if (cnt == CW'(K_NUM - 1)) begin
                            cnt       <= '0;
                            state     <= DIV;
                            div_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DIV: begin
                    if (done_x && done_y) begin
                        bus.out_x <= quo_x;
                        bus.out_y <= quo_y;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        sum_x <= '0;
                        sum_y <= '0;
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Both dividers share start/abort, so their done pulses coincide.
    seq_div_const #(.SUM_W(SUM_W), .DIVISOR(K_NUM), .Q_W(HALF)) u_div_x (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (clear),
        .start (div_start),
        .dvd   (sum_x),
        .done  (done_x),
        .quo   (quo_x)
    );

    seq_div_const #(.SUM_W(SUM_W), .DIVISOR(K_NUM), .Q_W(HALF)) u_div_y (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (clear),
        .start (div_start),
        .dvd   (sum_y),
        .done  (done_y),
        .quo   (quo_y)
    );

endmodule

// File: tb/tb_pos_seq_ctrl.sv
// Self-checking bench for pos_seq_ctrl: directed and random frames against an
// arithmetic average model, plus back-pressure, clear and reset-in-DIV scenarios.
module tb_pos_seq_ctrl;

    localparam int LBL_LEN = 10;
    localparam int K_NUM   = 5;
    localparam int LAT     = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_x   = 0;
    int last_y   = 0;

    pos_seq_ctrl_if #(.LBL_LEN(LBL_LEN)) bus ();

    pos_seq_ctrl #(.LBL_LEN(LBL_LEN), .K_NUM(K_NUM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input int x, input int y);
        return {5'(x), 5'(y)};
    endfunction

    // abort: 0 = normal frame, 1 = clear pulsed in DIV, 2 = reset pulsed in DIV
    task automatic run_frame(input logic [9:0] l[K_NUM], input int hold, input int abort);
        int sx, sy, n, ex, ey;
        sx = 0;
        sy = 0;
        for (int i = 0; i < K_NUM; i++) begin
            sx += int'(l[i][9:5]);
            sy += int'(l[i][4:0]);
        end
        ex = sx / K_NUM;
        ey = sy / K_NUM;
        for (int i = 0; i < K_NUM; i++) begin
            bus.in_valid = 1'b1;
            bus.in_lbl   = l[i];
            check_eq("in_ready_collect", int'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_lbl   = 10'($urandom);
        if (abort != 0) begin
            repeat (3) @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (abort == 1) begin
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
                check_eq("clr_busy", int'(busy), 0);
                check_eq("clr_out_valid", int'(bus.out_valid), 0);
                check_eq("clr_in_ready", int'(bus.in_ready), 1);
                check_eq("clr_out_x_kept", int'(bus.out_x), last_x);
                check_eq("clr_out_y_kept", int'(bus.out_y), last_y);
            end else begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_out_valid", int'(bus.out_valid), 0);
                check_eq("rst_in_ready", int'(bus.in_ready), 1);
                check_eq("rst_out_x", int'(bus.out_x), 0);
                check_eq("rst_out_y", int'(bus.out_y), 0);
                last_x = 0;
                last_y = 0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            return;
        end
        n = 0;
        while (!bus.out_valid && n < 40) begin
            check_eq("div_in_ready", int'(bus.in_ready), 0);
            check_eq("div_busy", int'(busy), 1);
            @(posedge clk); #1;
            bus.in_lbl = 10'($urandom);
            n++;
        end
        check_eq("latency", n, LAT);
        check_eq("out_x", int'(bus.out_x), ex);
        check_eq("out_y", int'(bus.out_y), ey);
        last_x = ex;
        last_y = ey;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", int'(bus.out_valid), 1);
            check_eq("hold_in_ready", int'(bus.in_ready), 0);
            check_eq("hold_out_x", int'(bus.out_x), ex);
            check_eq("hold_out_y", int'(bus.out_y), ey);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("post_out_valid", int'(bus.out_valid), 0);
        check_eq("post_in_ready", int'(bus.in_ready), 1);
        check_eq("post_busy", int'(busy), 0);
    endtask

    logic [9:0] fr[K_NUM];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_lbl    = '0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("reset_in_ready", int'(bus.in_ready), 1);
        check_eq("reset_out_valid", int'(bus.out_valid), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_out_x", int'(bus.out_x), 0);
        check_eq("reset_out_y", int'(bus.out_y), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fr = '{mk(1, 2), mk(3, 4), mk(5, 6), mk(7, 8), mk(9, 10)};
        run_frame(fr, 0, 0);
        fr = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        run_frame(fr, 0, 0);
        fr = '{mk(1, 0), mk(1, 0), mk(1, 0), mk(1, 0), mk(2, 4)};
        run_frame(fr, 20, 0);

        // Partial frame dropped by clear
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_lbl   = mk(31, 31);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clear_in_ready", int'(bus.in_ready), 1);
        fr = '{mk(2, 2), mk(2, 2), mk(2, 2), mk(2, 2), mk(2, 2)};
        run_frame(fr, 0, 0);

        fr = '{mk(30, 1), mk(29, 2), mk(28, 3), mk(27, 4), mk(26, 5)};
        run_frame(fr, 0, 1);
        fr = '{mk(4, 9), mk(6, 11), mk(8, 13), mk(10, 15), mk(12, 17)};
        run_frame(fr, 1, 0);

        fr = '{mk(31, 0), mk(31, 0), mk(31, 0), mk(31, 0), mk(31, 0)};
        run_frame(fr, 0, 2);
        fr = '{mk(7, 3), mk(14, 6), mk(21, 9), mk(28, 12), mk(0, 1)};
        run_frame(fr, 0, 0);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < K_NUM; i++) fr[i] = 10'($urandom);
            run_frame(fr, int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
